mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller that consumes the EX/MEM pipeline register outputs: integer/vector ALU results, swap data, and the enable/flag bits.
- Executes scalar and vector loads/stores over an ELEM_SIZE-wide data-memory port with a req/ack handshake, splitting each access into element beats.
- Stalls upstream while an access is in flight.
- Presents registered write-back results to the WB stage.

Parameters:
- REGI_SIZE, 16, scalar register width
- ELEM_SIZE, 8, vector element width and memory word width
- VECT_SIZE, 8, elements per vector
- MEMO_LINES, 64, data-memory depth in ELEM_SIZE words
- ADDR_BITS, $clog2(MEMO_LINES), memory address width
- TIMEOUT_CYCLES, 16, ack watchdog limit (optional feature only)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ialu_res_i  in  REGI_SIZE  scalar ALU result; effective address for memory ops
- iswa_res_i  in  REGI_SIZE  scalar store data
- valu_res_i  in  ELEM_SIZE*VECT_SIZE  vector ALU result
- vswa_res_i  in  ELEM_SIZE*VECT_SIZE  vector store data
- enableMem_i, enableReg_i, enableJump_i  in  1 each  stage enables
- flagMemRead_i, flagMemWrite_i  in  1 each  access type
- vecOp_i  in  1  1 = vector access, 0 = scalar access
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_BITS  word address
- mem_wdata_o  out  ELEM_SIZE  write data
- mem_rdata_i  in  ELEM_SIZE  read data, valid with ack
- mem_ack_i  in  1  beat complete
- stall_o  out  1  hold upstream pipeline
- wb_valid_o  out  1  write-back result valid, one-cycle pulse
- wb_ireg_o  out  REGI_SIZE  scalar write-back value
- wb_vreg_o  out  ELEM_SIZE*VECT_SIZE  vector write-back value
- enableReg_o, enableJump_o  out  1 each  forwarded enables, aligned with wb_valid_o
- err_o  out  1  access timeout (optional feature only)

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asynchronously aborts any access in flight, so mem_req_o drops immediately.
- FSM states:
  - IDLE
  - ACCESS
- Start condition: start = enableMem_i & (flagMemRead_i | flagMemWrite_i) while in IDLE.
  - If both flags are set, the access is a write.
  - If enableMem_i=0, the flags are ignored.
- IDLE, no start: register ialu_res_i→wb_ireg_o, valu_res_i→wb_vreg_o and the enables. Set wb_valid_o = enableReg_i | enableJump_i. Latency is 1 cycle.
- IDLE, start:
  - Latch address, data, type, vecOp_i and enables.
  - Clear the beat counter; next state is ACCESS. wb_valid_o is 0 on the next edge.
  - Beat count N: VECT_SIZE if vector, REGI_SIZE/ELEM_SIZE (=2) if scalar.
- ACCESS:
  - mem_req_o=1, mem_we_o=write.
  - mem_addr_o = (addr + beat) mod MEMO_LINES; wraps at MEMO_LINES-1 → 0.
  - mem_wdata_o = store data[beat*ELEM_SIZE +: ELEM_SIZE]. Order is little-endian: beat 0 carries the LSBs.
  - On mem_ack_i for a read: capture mem_rdata_i into result[beat*ELEM_SIZE +: ELEM_SIZE].
  - On mem_ack_i: beat++.
  - req stays high into the next beat (back-to-back), and address and data hold until ack.
- Last ack (beat==N-1):
  - Register the write-back outputs and go to IDLE.
  - The next cycle has wb_valid_o = latched enableReg.
  - For a read: wb_ireg_o/wb_vreg_o carry the loaded data. The scalar read fills wb_ireg_o; the vector read fills wb_vreg_o. The other output carries the latched ALU result.
  - For a write: write-back carries the latched ALU results.
- stall_o = start | (state==ACCESS), combinational. Upstream advances on the first edge after stall_o falls.
- Timing with acks arriving in the same cycle as req: accept at cycle T, beats at T+1..T+N, wb_valid_o at T+N+1.
- A new start in the wb_valid_o cycle is legal (back-to-back accesses).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on every ack.
  - If it reaches TIMEOUT_CYCLES in ACCESS: drop req, go to IDLE, pulse err_o and wb_valid_o=0.
  - err_o is a 1-cycle pulse.
- Undefined: the FSM waits indefinitely for ack, and err_o is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum (IDLE, ACCESS)
  - the ADDR_BITS function
  - the SCALAR_BEATS constant
- Optional sub-module mem_beat_seq: beat counter, address generation, element slice/merge.

Test Plan:
- Non-mem op, enableReg=1, ialu=0x1234 → next cycle: wb_valid=1, wb_ireg=0x1234, stall never high.
- Scalar read, addr 0x05, memory [5]=0xCD, [6]=0xAB, immediate ack → 2 req cycles at addresses 5,6; stall high 3 cycles; wb_ireg=0xABCD.
- Vector write, addr 62, vswa=0x0807060504030201, ack delayed 2 cycles per beat:
  - addresses are 62,63,0,...,5 (wraps at 63→0);
  - data bytes are 01..08;
  - wb_vreg = valu.
- Both flags set with enableMem=1 → treated as a write (mem_we_o=1); enableMem=0 with flags set → no req.
- rst_i asserted during beat 3 of a vector read → mem_req_o and stall_o drop immediately; all outputs are 0.
- MEM_TIMEOUT_EN, no ack for 16 cycles → err_o pulses once, FSM in IDLE, no wb_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the memory-stage controller.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int REGI_SIZE_DEF = 16;
  localparam int ELEM_SIZE_DEF = 8;
  // A scalar access moves one register split into memory-word beats.
  localparam int SCALAR_BEATS  = REGI_SIZE_DEF / ELEM_SIZE_DEF;

  function automatic int addr_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Element-wide data-memory port: one beat per req/ack handshake, rdata valid with ack.
interface mem_stage_ctrl_if
  import mem_stage_pkg::*;
#(
  parameter int ELEM_SIZE = ELEM_SIZE_DEF,
  parameter int ADDR_BITS = addr_bits(64)
);
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [ELEM_SIZE-1:0] mem_wdata_o;
  logic [ELEM_SIZE-1:0] mem_rdata_i;
  logic                 mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: 1-cycle pass-through, or element-beat load/store with upstream stall until done.
// Optional ack watchdog with err_o pulse under MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int REGI_SIZE  = REGI_SIZE_DEF,
  parameter int ELEM_SIZE  = ELEM_SIZE_DEF,
  parameter int VECT_SIZE  = 8,
  parameter int MEMO_LINES = 64,
  parameter int ADDR_BITS  = addr_bits(MEMO_LINES)
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [REGI_SIZE-1:0]           ialu_res_i,
  input  logic [REGI_SIZE-1:0]           iswa_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vswa_res_i,
  input  logic                           enableMem_i,
  input  logic                           enableReg_i,
  input  logic                           enableJump_i,
  input  logic                           flagMemRead_i,
  input  logic                           flagMemWrite_i,
  input  logic                           vecOp_i,
  mem_stage_ctrl_if.master               mem,
  output logic                           stall_o,
  output logic                           wb_valid_o,
  output logic [REGI_SIZE-1:0]           wb_ireg_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] wb_vreg_o,
  output logic                           enableReg_o,
  output logic                           enableJump_o,
  output logic                           err_o
);

  localparam int VW       = ELEM_SIZE * VECT_SIZE;
  localparam int BB       = $clog2(VECT_SIZE + 1);
  localparam int N_SCALAR = SCALAR_BEATS;

  state_t               state_q, state_d;
  logic [BB-1:0]        beat_q, beat_d;
  logic                 we_q, we_d, vec_q, vec_d;
  logic                 en_reg_q, en_reg_d, en_jump_q, en_jump_d;
  logic [REGI_SIZE-1:0] ialu_q, ialu_d;
  logic [VW-1:0]        valu_q, valu_d, sdata_q, sdata_d, ldata_q, ldata_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REGI_SIZE-1:0] wb_ireg_q, wb_ireg_d;
  logic [VW-1:0]        wb_vreg_q, wb_vreg_d;
  logic                 wb_en_reg_q, wb_en_reg_d, wb_en_jump_q, wb_en_jump_d;
  logic                 start, in_access, last_beat;
  logic [BB-1:0]        final_beat;
  logic [ADDR_BITS-1:0] addr_cur;
  logic [ELEM_SIZE-1:0] elem_cur;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign start      = (state_q == IDLE) & enableMem_i & (flagMemRead_i | flagMemWrite_i);
  assign in_access  = (state_q == ACCESS);
  assign stall_o    = start | in_access;
  assign final_beat = vec_q ? BB'(VECT_SIZE - 1) : BB'(N_SCALAR - 1);
  assign last_beat  = (beat_q == final_beat);

  // Word address wraps around the end of memory; beat 0 carries the low element.
  always_comb begin
    int sum;
    sum = int'(ialu_q[ADDR_BITS-1:0]) + int'(beat_q);
    if (sum >= MEMO_LINES) sum = sum - MEMO_LINES;
    addr_cur = ADDR_BITS'(sum);
    elem_cur = '0;
    for (int i = 0; i < VECT_SIZE; i++) begin
      if (beat_q == BB'(i)) elem_cur = sdata_q[i*ELEM_SIZE +: ELEM_SIZE];
    end
  end

  assign mem.mem_req_o   = in_access;
  assign mem.mem_we_o    = in_access & we_q;
  assign mem.mem_addr_o  = in_access ? addr_cur : '0;
  assign mem.mem_wdata_o = in_access ? elem_cur : '0;

  assign wb_valid_o   = wb_valid_q;
  assign wb_ireg_o    = wb_ireg_q;
  assign wb_vreg_o    = wb_vreg_q;
  assign enableReg_o  = wb_en_reg_q;
  assign enableJump_o = wb_en_jump_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    we_d         = we_q;
    vec_d        = vec_q;
    en_reg_d     = en_reg_q;
    en_jump_d    = en_jump_q;
    ialu_d       = ialu_q;
    valu_d       = valu_q;
    sdata_d      = sdata_q;
    ldata_d      = ldata_q;
    wb_valid_d   = 1'b0;
    wb_ireg_d    = wb_ireg_q;
    wb_vreg_d    = wb_vreg_q;
    wb_en_reg_d  = 1'b0;
    wb_en_jump_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCESS;
          beat_d    = '0;
          we_d      = flagMemWrite_i;
          vec_d     = vecOp_i;
          en_reg_d  = enableReg_i;
          en_jump_d = enableJump_i;
          ialu_d    = ialu_res_i;
          valu_d    = valu_res_i;
          sdata_d   = '0;
          if (vecOp_i) sdata_d = vswa_res_i;
          else         sdata_d[REGI_SIZE-1:0] = iswa_res_i;
          ldata_d   = '0;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          wb_ireg_d    = ialu_res_i;
          wb_vreg_d    = valu_res_i;
          wb_en_reg_d  = enableReg_i;
          wb_en_jump_d = enableJump_i;
          wb_valid_d   = enableReg_i | enableJump_i;
        end
      end
      ACCESS: begin
        if (mem.mem_ack_i) begin
          if (!we_q) begin
            for (int i = 0; i < VECT_SIZE; i++) begin
              if (beat_q == BB'(i)) ldata_d[i*ELEM_SIZE +: ELEM_SIZE] = mem.mem_rdata_i;
            end
          end
          beat_d = beat_q + 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d  = '0;
`endif
          if (last_beat) begin
            state_d      = IDLE;
            wb_valid_d   = en_reg_q;
            wb_en_reg_d  = en_reg_q;
            wb_en_jump_d = en_jump_q;
            wb_ireg_d    = ialu_q;
            wb_vreg_d    = valu_q;
            // Loaded data replaces only the register file the access targets.
            if (!we_q && vec_q)  wb_vreg_d = ldata_d;
            if (!we_q && !vec_q) wb_ireg_d = ldata_d[REGI_SIZE-1:0];
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      we_q         <= 1'b0;
      vec_q        <= 1'b0;
      en_reg_q     <= 1'b0;
      en_jump_q    <= 1'b0;
      ialu_q       <= '0;
      valu_q       <= '0;
      sdata_q      <= '0;
      ldata_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_ireg_q    <= '0;
      wb_vreg_q    <= '0;
      wb_en_reg_q  <= 1'b0;
      wb_en_jump_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      we_q         <= we_d;
      vec_q        <= vec_d;
      en_reg_q     <= en_reg_d;
      en_jump_q    <= en_jump_d;
      ialu_q       <= ialu_d;
      valu_q       <= valu_d;
      sdata_q      <= sdata_d;
      ldata_q      <= ldata_d;
      wb_valid_q   <= wb_valid_d;
      wb_ireg_q    <= wb_ireg_d;
      wb_vreg_q    <= wb_vreg_d;
      wb_en_reg_q  <= wb_en_reg_d;
      wb_en_jump_q <= wb_en_jump_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: random ops checked against a queue/array reference model.
module tb_mem_stage_ctrl;
  localparam int RS = 16;
  localparam int ES = 8;
  localparam int VS = 8;
  localparam int ML = 64;
  localparam int AB = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RS-1:0]    ialu_res_i, iswa_res_i;
  logic [ES*VS-1:0] valu_res_i, vswa_res_i;
  logic enableMem_i, enableReg_i, enableJump_i, flagMemRead_i, flagMemWrite_i, vecOp_i;
  logic stall_o, wb_valid_o, enableReg_o, enableJump_o, err_o;
  logic [RS-1:0]    wb_ireg_o;
  logic [ES*VS-1:0] wb_vreg_o;

  mem_stage_ctrl_if #(.ELEM_SIZE(ES), .ADDR_BITS(AB)) mif ();

  mem_stage_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .ialu_res_i(ialu_res_i), .iswa_res_i(iswa_res_i),
    .valu_res_i(valu_res_i), .vswa_res_i(vswa_res_i),
    .enableMem_i(enableMem_i), .enableReg_i(enableReg_i), .enableJump_i(enableJump_i),
    .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i), .vecOp_i(vecOp_i),
    .mem(mif),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_ireg_o(wb_ireg_o), .wb_vreg_o(wb_vreg_o),
    .enableReg_o(enableReg_o), .enableJump_o(enableJump_o), .err_o(err_o)
  );

  typedef struct packed { logic [AB-1:0] addr; logic we; logic [ES-1:0] wdata; } beat_t;
  typedef struct packed { logic [RS-1:0] ireg; logic [ES*VS-1:0] vreg; logic er; logic ej; } wb_t;

  beat_t      beat_q[$];
  wb_t        wb_q[$];
  int         dly_q[$];
  logic [7:0] mem_arr [ML];
  logic [7:0] ref_mem [ML];
  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write-back monitor
  always @(negedge clk) begin
    wb_t e;
    if (err_o) err_seen++;
    if (wb_valid_o) begin
      if (wb_q.size() == 0) chk("unexpected_wb", 128'(wb_valid_o), 128'(0));
      else begin
        e = wb_q.pop_front();
        chk("wb", 128'({wb_ireg_o, wb_vreg_o, enableReg_o, enableJump_o}), 128'(e));
      end
    end
  end

  // Memory responder: checks each beat once, acks after its scheduled delay
  int wait_left = 0;
  bit fresh = 1'b1;
  initial begin
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = '0;
  end
  always @(negedge clk) begin
    beat_t e;
    if (rst || !mif.mem_req_o) begin
      mif.mem_ack_i = 1'b0;
      fresh = 1'b1;
    end else begin
      if (fresh) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_req", 128'(mif.mem_req_o), 128'(0));
          wait_left = 0;
        end else begin
          e = beat_q.pop_front();
          chk("beat_addr", 128'(mif.mem_addr_o), 128'(e.addr));
          chk("beat_we", 128'(mif.mem_we_o), 128'(e.we));
          if (e.we) chk("beat_wdata", 128'(mif.mem_wdata_o), 128'(e.wdata));
          wait_left = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        end
        fresh = 1'b0;
      end
      if (wait_left == 0) begin
        mif.mem_ack_i   = 1'b1;
        mif.mem_rdata_i = mem_arr[mif.mem_addr_o];
        if (mif.mem_we_o) mem_arr[mif.mem_addr_o] = mif.mem_wdata_o;
        fresh = 1'b1;
      end else begin
        mif.mem_ack_i = 1'b0;
        wait_left--;
      end
    end
  end

  task automatic bubble();
    enableMem_i    = 1'b0;
    enableReg_i    = 1'b0;
    enableJump_i   = 1'b0;
    flagMemRead_i  = 1'($urandom);
    flagMemWrite_i = 1'($urandom);
    vecOp_i        = 1'($urandom);
    ialu_res_i     = 16'($urandom);
    iswa_res_i     = 16'($urandom);
    valu_res_i     = {$urandom, $urandom};
    vswa_res_i     = {$urandom, $urandom};
  endtask

  task automatic drive(input logic em, rd, wr, vec, er, ej,
                       input logic [15:0] ialu, iswa, input logic [63:0] valu, vswa);
    enableMem_i = em; flagMemRead_i = rd; flagMemWrite_i = wr; vecOp_i = vec;
    enableReg_i = er; enableJump_i = ej;
    ialu_res_i = ialu; iswa_res_i = iswa; valu_res_i = valu; vswa_res_i = vswa;
  endtask

  // Reference model: whole-operation view of what memory and write-back must see.
  task automatic issue(input logic em, rd, wr, vec, er, ej,
                       input logic [15:0] ialu, iswa, input logic [63:0] valu, vswa,
                       input int dmode);
    int n, a, d, exp_stall, got_stall;
    logic [63:0] ld;
    logic [7:0]  sd;
    ld = '0;
    exp_stall = 0;
    if (em && (rd || wr)) begin
      n = vec ? VS : RS / ES;
      exp_stall = 1;
      for (int b = 0; b < n; b++) begin
        a  = (int'(ialu) + b) % ML;
        d  = (dmode < 0) ? int'($urandom_range(0, 3)) : dmode;
        sd = vec ? vswa[b*8 +: 8] : iswa[b*8 +: 8];
        exp_stall += d + 1;
        beat_q.push_back({6'(a), wr, wr ? sd : 8'h00});
        dly_q.push_back(d);
        if (wr) ref_mem[a] = sd;
        else    ld[b*8 +: 8] = ref_mem[a];
      end
      if (er) begin
        if (!wr && !vec)     wb_q.push_back({ld[15:0], valu, er, ej});
        else if (!wr && vec) wb_q.push_back({ialu, ld, er, ej});
        else                 wb_q.push_back({ialu, valu, er, ej});
      end
    end else if (er || ej) begin
      wb_q.push_back({ialu, valu, er, ej});
    end
    drive(em, rd, wr, vec, er, ej, ialu, iswa, valu, vswa);
    #1 got_stall = stall_o ? 1 : 0;
    @(posedge clk);
    #1 bubble();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!stall_o) break;
      got_stall++;
    end
    chk("stall_cycles", 128'(got_stall), 128'(exp_stall));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_stall;
    int exp_err;
    for (int i = 0; i < ML; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[5] = 8'hCD; ref_mem[5] = 8'hCD;
    mem_arr[6] = 8'hAB; ref_mem[6] = 8'hAB;

    // Reset with a live pass-through op on the inputs: outputs must stay 0.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0, 64'hFFFF, 64'h0);
    repeat (2) @(negedge clk);
    chk("reset_wb_valid", 128'(wb_valid_o), 128'(0));
    chk("reset_req", 128'(mif.mem_req_o), 128'(0));
    chk("reset_outputs", 128'({wb_ireg_o, wb_vreg_o, enableReg_o, enableJump_o, err_o, stall_o}), 128'(0));
    bubble();
    #2 rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0, 64'h0, 64'h0, 0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, 64'h55, 64'h0, 0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd62, 16'h0, 64'hDEAD_BEEF_0BAD_F00D,
          64'h0807060504030201, 2);
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd62, 16'h0, 64'h1, 64'h0, -1);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'hBEEF, 64'h2, 64'h0, 1);
    issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h7777, 64'h3, 64'h4, 0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 64'h5, 64'h0, 0);

    // Reset during beat 3 of a vector read
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd10, 16'h0, 64'h9, 64'h0);
    for (int b = 0; b < VS; b++) begin
      beat_q.push_back({6'(10 + b), 1'b0, 8'h00});
      dly_q.push_back(0);
    end
    @(posedge clk);
    #1 bubble();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_req", 128'(mif.mem_req_o), 128'(0));
    chk("abort_stall", 128'(stall_o), 128'(0));
    chk("abort_outputs", 128'({mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o, wb_valid_o,
                               wb_ireg_o, wb_vreg_o, enableReg_o, enableJump_o, err_o}), 128'(0));
    beat_q.delete();
    dly_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    // Missing ack: watchdog aborts after TIMEOUT_CYCLES (16) cycles in ACCESS.
    exp_err = 1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20, 16'h0, 64'h0, 64'h0);
    beat_q.push_back({6'd20, 1'b0, 8'h00});
    dly_q.push_back(100000);
    #1 got_stall = stall_o ? 1 : 0;
    @(posedge clk);
    #1 bubble();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall_o) break;
      got_stall++;
    end
    chk("timeout_stall_cycles", 128'(got_stall), 128'(17));
    @(negedge clk);
    beat_q.delete();
    dly_q.delete();
`else
    exp_err = 0;
    got_stall = 0;
`endif

    for (int t = 0; t < 150; t++) begin
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, -1);
    end

    repeat (3) @(negedge clk);
    chk("wb_queue_drained", 128'(wb_q.size()), 128'(0));
    chk("beat_queue_drained", 128'(beat_q.size()), 128'(0));
    chk("err_pulses", 128'(err_seen), 128'(exp_err));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
